fifo_stream_reader: RTL and testbench

Read-side drain engine for the synchronous `fifo_generic` buffer. It pops words from the FIFO's registered read port and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer. It presents the words on a valid/ready stream at up to one word per clock. Every `FRAME_LEN`-th word is tagged with `out_last`, so downstream consumers see framed packets.

---
 rtl/fifo_stream_reader.sv | 111 +++++++++++
 tb/tb_fifo_stream_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read-port FIFO onto a valid/ready
// stream. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency,
// and every FRAME_LEN-th word is tagged with out_last.
module fifo_stream_reader #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int FRAME_LEN       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       fifo_empty,
  output logic                       fifo_read,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  output logic                       out_last
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [1:0]                 buf_count;
  logic                       inflight;
  logic [CNT_W-1:0]           word_cnt;
  logic [FIFO_DATA_WIDTH-1:0] head_data;
  logic [FIFO_DATA_WIDTH-1:0] tail_data;
  logic                       head_last;
  logic                       tail_last;
  logic                       pop;
  logic                       cap_last;
  logic [2:0]                 occupancy;

  // Stream outputs come straight from the head register.
  always_comb begin
    out_valid = (buf_count != 2'd0);
    out_data  = head_data;
    out_last  = head_last;
  end

  // Issue a read only when the word is guaranteed a buffer slot next cycle;
  // a same-cycle pop frees a slot, so fifo_read depends on out_ready.
  always_comb begin
    pop       = out_valid & out_ready;
    cap_last  = (word_cnt == LAST_CNT);
    occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    fifo_read = enable & ~fifo_empty & (occupancy < 3'd2);
  end

  // Track the outstanding read and the position within the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_read;
      if (inflight) begin
        if (word_cnt == LAST_CNT) word_cnt <= '0;
        else                      word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Two-entry in-order buffer: capture into the tail, pop from the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_count <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (buf_count == 2'd0) begin
            head_data <= fifo_read_data;
            head_last <= cap_last;
          end else begin
            tail_data <= fifo_read_data;
            tail_last <= cap_last;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          // Draining to empty keeps the stale data but drops the last tag.
          if (buf_count == 2'd2) begin
            head_data <= tail_data;
            head_last <= tail_last;
          end else begin
            head_last <= 1'b0;
          end
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous capture and pop: count holds, order is preserved.
          if (buf_count == 2'd1) begin
            head_data <= fifo_read_data;
            head_last <= cap_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= fifo_read_data;
            tail_last <= cap_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a behavioural
// registered-read FIFO feeding it.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_read;
  logic [7:0] fifo_read_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;

  int checks = 0;
  int failures = 0;

  fifo_stream_reader #(.FIFO_DATA_WIDTH(8), .FRAME_LEN(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .fifo_read_data(fifo_read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // FIFO model: writes from the stimulus process, registered read port.
  logic [7:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (!reset && fifo_read) begin
      fifo_read_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  // Words accepted by the reader but not yet popped must never exceed 2.
  int outst = 0;
  int max_outst = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) outst <= 0;
    else outst <= outst + (fifo_read ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
  end
  always @(negedge clk) if (outst > max_outst) max_outst = outst;

  // Per-cycle history and received-word log.
  logic fr_h [0:127];
  logic ov_h [0:127];
  logic [7:0] od_h [0:127];
  int hc = 0;
  logic [7:0] rx_d [$];
  logic       rx_l [$];
  int         rx_c [$];

  task automatic push(input logic [7:0] v);
    mem[wp[7:0]] = v;
    wp = wp + 1;
  endtask

  task automatic clear_hist();
    hc = 0;
    rx_d.delete();
    rx_l.delete();
    rx_c.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    wp = rp;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_hist();
  endtask

  task automatic run_cycles(input int n, input logic [63:0] rdy, input logic [63:0] en);
    for (int i = 0; i < n; i++) begin
      out_ready = rdy[i];
      enable = en[i];
      #1;
      fr_h[hc] = fifo_read;
      ov_h[hc] = out_valid;
      od_h[hc] = out_data;
      if (out_valid && out_ready) begin
        rx_d.push_back(out_data);
        rx_l.push_back(out_last);
        rx_c.push_back(hc);
      end
      hc++;
      @(posedge clk); #1;
    end
  endtask

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (fifo_read !== 1'b0) begin failures++; $display("FAIL reset_fifo_read got=%b exp=0", fifo_read); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_fr;
    logic [7:0] exp_ov;
    logic [7:0] exp_d [0:3];
    exp_fr = 8'b0000_1111;
    exp_ov = 8'b0011_1100;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_cycles(8, ALL1, ALL1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (fr_h[i] !== exp_fr[i]) begin failures++; $display("FAIL basic_fifo_read cyc=%0d got=%b exp=%b", i, fr_h[i], exp_fr[i]); end
      checks++; if (ov_h[i] !== exp_ov[i]) begin failures++; $display("FAIL basic_out_valid cyc=%0d got=%b exp=%b", i, ov_h[i], exp_ov[i]); end
    end
    checks++;
    if (rx_d.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", rx_d.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (rx_d[k] !== exp_d[k]) begin failures++; $display("FAIL basic_data word=%0d got=%h exp=%h", k, rx_d[k], exp_d[k]); end
        checks++; if (rx_l[k] !== (k == 3)) begin failures++; $display("FAIL basic_last word=%0d got=%b exp=%b", k, rx_l[k], (k == 3)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int reads;
    do_reset();
    for (int k = 0; k < 6; k++) push(8'hA0 + 8'(k));
    run_cycles(10, 64'h0, ALL1);
    reads = 0;
    for (int i = 0; i < 10; i++) if (fr_h[i] === 1'b1) reads++;
    checks++; if (reads != 2) begin failures++; $display("FAIL bp_reads_held got=%0d exp=2", reads); end
    checks++; if (fr_h[9] !== 1'b0) begin failures++; $display("FAIL bp_read_low got=%b exp=0", fr_h[9]); end
    for (int i = 2; i < 10; i++) begin
      checks++;
      if (ov_h[i] !== 1'b1 || od_h[i] !== 8'hA0) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/a0", i, ov_h[i], od_h[i]);
      end
    end
    run_cycles(12, ALL1, ALL1);
    checks++;
    if (rx_d.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", rx_d.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (rx_d[k] !== 8'hA0 + 8'(k)) begin failures++; $display("FAIL bp_data word=%0d got=%h exp=%h", k, rx_d[k], 8'hA0 + 8'(k)); end
        checks++; if (rx_c[k] != 10 + k) begin failures++; $display("FAIL bp_nogap word=%0d got=%0d exp=%0d", k, rx_c[k], 10 + k); end
        checks++; if (rx_l[k] !== (k == 3)) begin failures++; $display("FAIL bp_last word=%0d got=%b exp=%b", k, rx_l[k], (k == 3)); end
      end
    end
    checks++; if (max_outst > 2) begin failures++; $display("FAIL bp_overflow got=%0d exp<=2", max_outst); end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int k = 0; k < 8; k++) push(8'hB0 + 8'(k));
    run_cycles(24, {32{2'b01}}, ALL1);
    checks++;
    if (rx_d.size() != 8) begin failures++; $display("FAIL alt_count got=%0d exp=8", rx_d.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (rx_d[k] !== 8'hB0 + 8'(k)) begin failures++; $display("FAIL alt_data word=%0d got=%h exp=%h", k, rx_d[k], 8'hB0 + 8'(k)); end
        checks++; if (rx_l[k] !== (k == 3 || k == 7)) begin failures++; $display("FAIL alt_last word=%0d got=%b exp=%b", k, rx_l[k], (k == 3 || k == 7)); end
      end
    end
    checks++; if (max_outst > 2) begin failures++; $display("FAIL alt_overflow got=%0d exp<=2", max_outst); end
  endtask

  task automatic test_sparse();
    int rd_cyc [$];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push(8'hC0 + 8'(k));
      run_cycles(5, ALL1, ALL1);
    end
    for (int i = 0; i < hc; i++) if (fr_h[i] === 1'b1) rd_cyc.push_back(i);
    checks++;
    if (rd_cyc.size() != 6 || rx_d.size() != 6) begin
      failures++; $display("FAIL sparse_count reads=%0d words=%0d exp=6/6", rd_cyc.size(), rx_d.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (rd_cyc[k] != 5 * k) begin failures++; $display("FAIL sparse_read_cyc word=%0d got=%0d exp=%0d", k, rd_cyc[k], 5 * k); end
        checks++; if (rx_c[k] != rd_cyc[k] + 2) begin failures++; $display("FAIL sparse_latency word=%0d got=%0d exp=%0d", k, rx_c[k], rd_cyc[k] + 2); end
        checks++; if (rx_d[k] !== 8'hC0 + 8'(k)) begin failures++; $display("FAIL sparse_data word=%0d got=%h exp=%h", k, rx_d[k], 8'hC0 + 8'(k)); end
        checks++; if (rx_l[k] !== (k == 3)) begin failures++; $display("FAIL sparse_last word=%0d got=%b exp=%b", k, rx_l[k], (k == 3)); end
      end
    end
  endtask

  task automatic test_enable_drop();
    int reads;
    do_reset();
    for (int k = 0; k < 5; k++) push(8'hD0 + 8'(k));
    run_cycles(10, ALL1, 64'h3);
    reads = 0;
    for (int i = 0; i < 10; i++) if (fr_h[i] === 1'b1) reads++;
    checks++; if (reads != 2) begin failures++; $display("FAIL en_reads got=%0d exp=2", reads); end
    checks++; if (rx_d.size() != 2) begin failures++; $display("FAIL en_drained got=%0d exp=2", rx_d.size()); end
    run_cycles(10, ALL1, ALL1);
    checks++;
    if (rx_d.size() != 5) begin failures++; $display("FAIL en_count got=%0d exp=5", rx_d.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (rx_d[k] !== 8'hD0 + 8'(k)) begin failures++; $display("FAIL en_data word=%0d got=%h exp=%h", k, rx_d[k], 8'hD0 + 8'(k)); end
        checks++; if (rx_l[k] !== (k == 3)) begin failures++; $display("FAIL en_last word=%0d got=%b exp=%b", k, rx_l[k], (k == 3)); end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    for (int k = 0; k < 6; k++) push(8'hE0 + 8'(k));
    run_cycles(4, 64'h0, ALL1);
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin failures++; $display("FAIL mid_pre_valid got=%b/%b exp=1/0", out_valid, out_last); end
    checks++; if (fifo_read !== 1'b1) begin failures++; $display("FAIL mid_pre_read got=%b exp=1", fifo_read); end
    reset = 1'b1;
    wp = rp;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL mid_async_last got=%b exp=0", out_last); end
    checks++; if (fifo_read !== 1'b0) begin failures++; $display("FAIL mid_async_read got=%b exp=0", fifo_read); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mid_async_data got=%h exp=00", out_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_hist();
    for (int k = 0; k < 4; k++) push(8'hF0 + 8'(k));
    run_cycles(8, ALL1, ALL1);
    checks++;
    if (rx_d.size() != 4) begin failures++; $display("FAIL mid_count got=%0d exp=4", rx_d.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (rx_d[k] !== 8'hF0 + 8'(k)) begin failures++; $display("FAIL mid_data word=%0d got=%h exp=%h", k, rx_d[k], 8'hF0 + 8'(k)); end
        checks++; if (rx_l[k] !== (k == 3)) begin failures++; $display("FAIL mid_last word=%0d got=%b exp=%b", k, rx_l[k], (k == 3)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_alternating();
    test_sparse();
    test_enable_drop();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
